// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared stall, size and FSM encodings for the data-memory sequencer
package dmem_ctrl_pkg;

    localparam int StallBus = 6;
    localparam int STALL_EX = 2;
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Encoding 3 is illegal and behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  is_misaligned = 1'b0;
            SIZE_H:  is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - addr/data handshake bus between the sequencer and the data SRAM
interface dmem_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - byte-lane strobes, store data replication and load extraction/extension
module dmem_align
    import dmem_ctrl_pkg::*;
(
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata_ext
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_rdata >> {i_addr_lo, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wstrb     = 4'b0000;
        o_wdata     = i_wdata;
        o_rdata_ext = i_rdata;
        case (i_size)
            SIZE_B: begin
                if (i_wr) o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_wdata[7:0]}};
                o_rdata_ext = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SIZE_H: begin
                if (i_wr) o_wstrb = 4'b0011 << i_addr_lo;
                o_wdata     = {2{i_wdata[15:0]}};
                o_rdata_ext = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                if (i_wr) o_wstrb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - turns one EX load/store into a single addr/data bus transaction and holds the pipeline
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [StallBus-1:0] i_stall,
    input  logic                i_req_valid,
    input  logic                i_req_wr,
    input  logic [1:0]          i_req_size,
    input  logic                i_req_unsigned,
    input  logic [31:0]         i_req_addr,
    input  logic [31:0]         i_req_wdata,
    dmem_ctrl_if.master         bus,
    output logic                o_stallreq,
    output logic [31:0]         o_load_result,
    output logic                o_done,
    output logic                o_addr_err
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_wr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [31:0] r_load_result;

    logic        w_idle;
    logic        w_ex_stop;
    logic        w_misaligned;
    logic        w_accept;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata_ext;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_ex_stop    = (i_stall[STALL_EX] == Stop);
    assign w_misaligned = is_misaligned(i_req_size, i_req_addr[1:0]);

    // One aligner serves both paths: live request fields in IDLE, latched fields on the return path.
    dmem_align u_align (
        .i_wr        (w_idle ? i_req_wr        : r_wr),
        .i_size      (w_idle ? i_req_size      : r_size),
        .i_unsigned  (w_idle ? i_req_unsigned  : r_unsigned),
        .i_addr_lo   (w_idle ? i_req_addr[1:0] : r_addr[1:0]),
        .i_wdata     (i_req_wdata),
        .i_rdata     (bus.data_rdata),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        o_stallreq  = 1'b0;
        o_addr_err  = 1'b0;
        o_done      = 1'b0;
        bus.data_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid && w_misaligned) begin
                    o_addr_err = 1'b1;
                end else if (i_req_valid) begin
                    o_stallreq = 1'b1;
                    if (!w_ex_stop) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                o_stallreq   = 1'b1;
                bus.data_req = 1'b1;
                if (bus.data_addr_ok) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                o_stallreq = 1'b1;
                if (bus.data_data_ok) w_state_nxt = ST_DONE;
            end
            default: begin
                // Held EX still shows the finished op; wait for it to move on rather than reissue.
                o_done = 1'b1;
                if (!w_ex_stop) w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr          <= 1'b0;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_addr        <= 32'h0;
            r_wstrb       <= 4'h0;
            r_wdata       <= 32'h0;
            r_load_result <= 32'h0;
        end else begin
            if (w_accept) begin
                r_wr       <= i_req_wr;
                r_size     <= (i_req_size == 2'd3) ? SIZE_W : i_req_size;
                r_unsigned <= i_req_unsigned;
                r_addr     <= i_req_addr;
                r_wstrb    <= w_wstrb;
                r_wdata    <= w_wdata;
            end
            if (r_state == ST_DATA && bus.data_data_ok && !r_wr) begin
                r_load_result <= w_rdata_ext;
            end
        end
    end

    assign bus.data_wr    = r_wr;
    assign bus.data_size  = r_size;
    assign bus.data_addr  = r_addr;
    assign bus.data_wstrb = r_wstrb;
    assign bus.data_wdata = r_wdata;
    assign o_load_result  = r_load_result;

endmodule
